smc_pwm_gen: RTL and testbench



---
 rtl/smc_pkg.sv | 35 +++
 rtl/smc_pwm_cmp.sv | 77 +++++++
 rtl/smc_pwm_gen.sv | 110 +++++++++++
 tb/tb_smc_pwm_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// -----------------------------------------------------------------------------
// smc_pkg
// Shared definitions for the stepper motor controller PWM engine: default
// channel count and counter width, the duty-field layout, the alignment-mode
// encoding and the prescaler mask helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package smc_pkg;

    localparam int SMC_CW   = 11;   // counter / period / duty magnitude width
    localparam int SMC_NCH  = 12;   // number of PWM channels
    localparam int DC_W     = 16;   // width of one duty-cycle field
    localparam int SIGN_BIT = 15;   // duty field sign: 0 drives MNP, 1 drives MNM

    typedef enum logic [1:0] {
        AM_OFF    = 2'b00,
        AM_LEFT   = 2'b01,
        AM_RIGHT  = 2'b10,
        AM_CENTER = 2'b11
    } smc_am_e;

    // Terminal value of the prescaler divide counter: a tick fires every
    // 2^pre QCLK cycles, i.e. when the counter reaches 2^pre - 1.
    function automatic logic [2:0] pre_mask(input logic [1:0] pre);
        logic [2:0] mask;
        case (pre)
            2'd0:    mask = 3'd0;
            2'd1:    mask = 3'd1;
            2'd2:    mask = 3'd3;
            default: mask = 3'd7;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/smc_pwm_cmp.sv
// -----------------------------------------------------------------------------
// smc_pwm_cmp
// One PWM channel: compares the shared counter against the channel's shadowed
// alignment mode and duty magnitude, then registers the active term onto the
// plus or minus coil pin selected by the duty sign.
// Ports:
//   QCLK, QRESET  clock, synchronous active-high reset
//   cnt           shared period counter value
//   per           shadowed period (0 = disabled)
//   am            shadowed alignment mode
//   dc            shadowed duty field (sign at SIGN_BIT, magnitude in [CW-1:0])
//   mnm, mnp      registered minus / plus coil drive
// -----------------------------------------------------------------------------
module smc_pwm_cmp
    import smc_pkg::*;
#(
    parameter int CW = SMC_CW
) (
    input  logic            QCLK,
    input  logic            QRESET,
    input  logic [CW-1:0]   cnt,
    input  logic [CW-1:0]   per,
    input  smc_am_e         am,
    input  logic [DC_W-1:0] dc,
    output logic            mnm,
    output logic            mnp
);

    logic [CW-1:0] d;
    logic          s;
    logic          a;
    logic [CW-1:0] lo;
    logic          unused_dc_bits;

    assign d = dc[CW-1:0];
    assign s = dc[SIGN_BIT];
    // Duty bits between the magnitude and the sign carry no meaning.
    assign unused_dc_bits = ^dc[SIGN_BIT-1:CW];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        a  = 1'b0;
        lo = '0;
        if (per != '0 && am != AM_OFF && d != '0) begin
            if (d >= per) begin
                a = 1'b1;                       // saturate to 100 %
            end else begin
                // d < per here, so per - d cannot underflow.
                case (am)
                    AM_LEFT:   a = (cnt < d);
                    AM_RIGHT:  a = (cnt >= per - d);
                    AM_CENTER: begin
                        lo = (per - d) >> 1;
                        a  = (cnt >= lo) && (cnt < lo + d);
                    end
                    default:   a = 1'b0;
                endcase
            end
        end
    end

    // The sign steers the active term to exactly one pin, so MNM and MNP can
    // never be high together.
    always_ff @(posedge QCLK) begin
        // NOTE: state is assigned with non-blocking <= so every register
        // samples pre-edge values regardless of statement order.
        if (QRESET) begin
            mnm <= 1'b0;
            mnp <= 1'b0;
        end else begin
            mnp <= a & ~s;
            mnm <= a &  s;
        end
    end

endmodule

// File: rtl/smc_pwm_gen.sv
// -----------------------------------------------------------------------------
// smc_pwm_gen
// Shared PWM timebase for NCH motor-coil channels: prescaler, period counter
// and double-buffered shadow registers, plus one smc_pwm_cmp per channel.
// Shadows reload while the shadow period is 0 and on every counter wrap, so
// live register writes only take effect at a period boundary.
// Ports:
//   QCLK, QRESET  clock, synchronous active-high reset
//   MCPER_I       live period (0 = disabled)
//   MCPRE_I       prescaler select, tick every 1/2/4/8 QCLK cycles
//   MCAM_I        per-channel alignment, channel k at [2k+1:2k]
//   MCDC_I        per-channel signed duty, channel k at [16k+15:16k]
//   MNM, MNP      minus / plus coil drive
//   PERIOD_END    one-cycle pulse in the cycle after the counter wraps
//   CNT           current counter value
// -----------------------------------------------------------------------------
module smc_pwm_gen
    import smc_pkg::*;
#(
    parameter int NCH = SMC_NCH,
    parameter int CW  = SMC_CW
) (
    input  logic                QCLK,
    input  logic                QRESET,
    input  logic [CW-1:0]       MCPER_I,
    input  logic [1:0]          MCPRE_I,
    input  logic [2*NCH-1:0]    MCAM_I,
    input  logic [DC_W*NCH-1:0] MCDC_I,
    output logic [NCH-1:0]      MNM,
    output logic [NCH-1:0]      MNP,
    output logic                PERIOD_END,
    output logic [CW-1:0]       CNT
);

    // Shadow copies of the live register fields.
    logic [CW-1:0]               per_q;
    logic [1:0]                  pre_q;
    logic [NCH-1:0][1:0]         am_q;
    logic [NCH-1:0][DC_W-1:0]    dc_q;

    logic [2:0]    presc_q;
    logic [CW-1:0] cnt_q;
    logic          period_end_q;

    logic enabled;
    logic tick;
    logic wrap;
    logic load;

    assign enabled = (per_q != '0);
    assign tick    = enabled && (presc_q == pre_mask(pre_q));
    assign wrap    = tick && (cnt_q == per_q - CW'(1));
    assign load    = !enabled || wrap;

    always_ff @(posedge QCLK) begin
        // NOTE: the shadow registers are reset like any other state: a zero
        // shadow period is the disabled state the reload path depends on.
        if (QRESET) begin
            per_q <= '0;
            pre_q <= '0;
            am_q  <= '0;
            dc_q  <= '0;
        end else if (load) begin
            per_q <= MCPER_I;
            pre_q <= MCPRE_I;
            am_q  <= MCAM_I;
            dc_q  <= MCDC_I;
        end
    end

    // A wrap only happens on a tick, where the prescaler restarts anyway, so a
    // new prescale ratio always starts from a clean divide phase.
    always_ff @(posedge QCLK) begin
        if (QRESET) begin
            presc_q      <= '0;
            cnt_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            period_end_q <= wrap;
            if (!enabled) begin
                presc_q <= '0;
                cnt_q   <= '0;
            end else if (tick) begin
                presc_q <= '0;
                cnt_q   <= wrap ? '0 : cnt_q + CW'(1);
            end else begin
                presc_q <= presc_q + 3'd1;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        smc_pwm_cmp #(
            .CW (CW)
        ) u_cmp (
            .QCLK   (QCLK),
            .QRESET (QRESET),
            .cnt    (cnt_q),
            .per    (per_q),
            .am     (smc_am_e'(am_q[k])),
            .dc     (dc_q[k]),
            .mnm    (MNM[k]),
            .mnp    (MNP[k])
        );
    end

    assign CNT        = cnt_q;
    assign PERIOD_END = period_end_q;

endmodule

// File: tb/tb_smc_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_smc_pwm_gen
// Directed bench for smc_pwm_gen. A cycle model (counter expressed as elapsed
// QCLK cycles scaled by the prescale ratio) pushes the expected outputs of
// every edge into a queue; the value is popped and compared on the following
// falling edge. Window masks and tallies add constant-valued checks of the
// expected pulse positions.
// -----------------------------------------------------------------------------
module tb_smc_pwm_gen;

    localparam int NCH = 12;
    localparam int CW  = 11;

    logic                QCLK = 1'b0;
    logic                QRESET;
    logic [CW-1:0]       MCPER_I;
    logic [1:0]          MCPRE_I;
    logic [2*NCH-1:0]    MCAM_I;
    logic [16*NCH-1:0]   MCDC_I;
    logic [NCH-1:0]      MNM;
    logic [NCH-1:0]      MNP;
    logic                PERIOD_END;
    logic [CW-1:0]       CNT;

    smc_pwm_gen #(.NCH(NCH), .CW(CW)) dut (
        .QCLK       (QCLK),
        .QRESET     (QRESET),
        .MCPER_I    (MCPER_I),
        .MCPRE_I    (MCPRE_I),
        .MCAM_I     (MCAM_I),
        .MCDC_I     (MCDC_I),
        .MNM        (MNM),
        .MNP        (MNP),
        .PERIOD_END (PERIOD_END),
        .CNT        (CNT)
    );

    always #5 QCLK = ~QCLK;

    typedef struct {
        logic [CW-1:0]  cnt;
        logic [NCH-1:0] mnp;
        logic [NCH-1:0] mnm;
        logic           pe;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Model state.
    logic [CW-1:0]     m_per = '0;
    logic [1:0]        m_pre = '0;
    logic [2*NCH-1:0]  m_am  = '0;
    logic [16*NCH-1:0] m_dc  = '0;
    int                m_cyc = 0;
    logic [NCH-1:0]    m_mnp = '0;
    logic [NCH-1:0]    m_mnm = '0;
    logic              m_pe  = 1'b0;

    // Observation tallies.
    int            n_smp, n_pe, n_mnp0, n_mnm0;
    logic [15:0]   mask_p0, mask_m1, mask_p2;
    int            prev_cnt = 0;
    logic [CW-1:0] obs_cnt  = '0;
    logic          obs_pe   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit active(input int am, input int p, input int d, input int c);
        int lo;
        if (p == 0 || am == 0 || d == 0) return 1'b0;
        if (d >= p) return 1'b1;
        lo = (p - d) / 2;
        case (am)
            1:       return c < d;
            2:       return c >= p - d;
            default: return (c >= lo) && (c < lo + d);
        endcase
    endfunction

    // Advance the model across the coming rising edge and queue its outputs.
    task automatic predict();
        exp_t        e;
        int          c;
        bit          a;
        bit          ld;
        logic [15:0] dc;
        if (QRESET) begin
            m_per = '0; m_pre = '0; m_am = '0; m_dc = '0;
            m_cyc = 0;  m_mnp = '0; m_mnm = '0; m_pe = 1'b0;
        end else begin
            c = (m_per == 0) ? 0 : (m_cyc >> m_pre);
            for (int k = 0; k < NCH; k++) begin
                dc = m_dc[16*k +: 16];
                a  = active(int'(m_am[2*k +: 2]), int'(m_per), int'(dc[CW-1:0]), c);
                m_mnp[k] = a && !dc[15];
                m_mnm[k] = a &&  dc[15];
            end
            if (m_per == 0) begin
                m_pe = 1'b0; m_cyc = 0; ld = 1'b1;
            end else if (m_cyc + 1 == (int'(m_per) << m_pre)) begin
                m_pe = 1'b1; m_cyc = 0; ld = 1'b1;
            end else begin
                m_pe = 1'b0; m_cyc++; ld = 1'b0;
            end
            if (ld) begin
                m_per = MCPER_I; m_pre = MCPRE_I; m_am = MCAM_I; m_dc = MCDC_I;
            end
        end
        e.cnt = (m_per == 0) ? '0 : CW'(m_cyc >> m_pre);
        e.mnp = m_mnp;
        e.mnm = m_mnm;
        e.pe  = m_pe;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("cnt", 32'(CNT), 32'(e.cnt));
            check("mnp", 32'(MNP), 32'(e.mnp));
            check("mnm", 32'(MNM), 32'(e.mnm));
            check("period_end", 32'(PERIOD_END), 32'(e.pe));
        end
        check("mnp_mnm_excl", 32'(MNP & MNM), 32'd0);
        n_smp++;
        if (PERIOD_END) n_pe++;
        if (MNP[0]) n_mnp0++;
        if (MNM[0]) n_mnm0++;
        if (prev_cnt < 16) begin
            if (MNP[0]) mask_p0[prev_cnt] = 1'b1;
            if (MNM[1]) mask_m1[prev_cnt] = 1'b1;
            if (MNP[2]) mask_p2[prev_cnt] = 1'b1;
        end
        prev_cnt = int'(CNT);
        obs_cnt  = CNT;
        obs_pe   = PERIOD_END;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            predict();
            @(negedge QCLK);
            sample();
        end
    endtask

    task automatic clear_tallies();
        n_smp = 0; n_pe = 0; n_mnp0 = 0; n_mnm0 = 0;
        mask_p0 = '0; mask_m1 = '0; mask_p2 = '0;
    endtask

    task automatic wait_pe(input string tag, input int lim);
        int i = 0;
        do begin
            step(1);
            i++;
        end while (!obs_pe && i < lim);
        check(tag, 32'(obs_pe), 32'd1);
    endtask

    task automatic wait_cnt(input string tag, input int val, input int lim);
        int i = 0;
        while (int'(obs_cnt) != val && i < lim) begin
            step(1);
            i++;
        end
        check(tag, 32'(obs_cnt), 32'(val));
    endtask

    task automatic set_ch(input int k, input logic [1:0] am, input logic [15:0] dc);
        MCAM_I[2*k +: 2]  = am;
        MCDC_I[16*k +: 16] = dc;
    endtask

    initial begin
        QRESET  = 1'b1;
        MCPER_I = '0;
        MCPRE_I = '0;
        MCAM_I  = '0;
        MCDC_I  = '0;
        clear_tallies();
        step(3);
        check("rst_cnt", 32'(CNT), 32'd0);
        check("rst_mnp", 32'(MNP), 32'd0);
        check("rst_mnm", 32'(MNM), 32'd0);
        check("rst_pe",  32'(PERIOD_END), 32'd0);

        // Disabled: period 0 with a live left-aligned duty.
        QRESET = 1'b0;
        set_ch(0, 2'b01, 16'd5);
        clear_tallies();
        step(20);
        check("dis_pe",   32'(n_pe),   32'd0);
        check("dis_mnp0", 32'(n_mnp0), 32'd0);
        check("dis_mnm0", 32'(n_mnm0), 32'd0);

        // P=10, left, positive D=3.
        MCPER_I = 11'd10;
        set_ch(0, 2'b01, 16'd3);
        wait_pe("t2_wait_pe", 20);
        clear_tallies();
        step(20);
        check("t2_mask_p0", 32'(mask_p0), 32'h0007);
        check("t2_n_pe",    32'(n_pe),    32'd2);
        check("t2_n_mnp0",  32'(n_mnp0),  32'd6);
        check("t2_n_mnm0",  32'(n_mnm0),  32'd0);

        // ch1 right negative D=4, ch2 center positive D=4.
        set_ch(0, 2'b00, 16'd0);
        set_ch(1, 2'b10, 16'h8004);
        set_ch(2, 2'b11, 16'h0004);
        wait_pe("t3_wait_pe", 20);
        clear_tallies();
        step(20);
        check("t3_mask_m1", 32'(mask_m1), 32'h03C0);
        check("t3_mask_p2", 32'(mask_p2), 32'h0078);

        // P=8, prescale /4, D=P saturates; then D=0 after the wrap.
        set_ch(1, 2'b00, 16'd0);
        set_ch(2, 2'b00, 16'd0);
        set_ch(0, 2'b01, 16'd8);
        MCPER_I = 11'd8;
        MCPRE_I = 2'd2;
        wait_pe("t4_wait_pe", 20);
        step(1);
        clear_tallies();
        step(64);
        check("t4_sat_mnp0", 32'(n_mnp0), 32'd64);
        check("t4_n_pe",     32'(n_pe),   32'd2);
        set_ch(0, 2'b01, 16'd0);
        clear_tallies();
        wait_pe("t4_wait_pe2", 40);
        check("t4_hold_until_wrap", 32'(n_mnp0), 32'(n_smp));
        step(1);
        clear_tallies();
        step(32);
        check("t4_d0_mnp0", 32'(n_mnp0), 32'd0);

        // Mid-period duty change is deferred to the wrap.
        MCPER_I = 11'd10;
        MCPRE_I = 2'd0;
        set_ch(0, 2'b01, 16'd2);
        wait_pe("t5_wait_pe", 40);
        wait_cnt("t5_reach_cnt4", 4, 20);
        set_ch(0, 2'b01, 16'd7);
        clear_tallies();
        wait_pe("t5_wait_pe2", 20);
        check("t5_old_pattern", 32'(n_mnp0), 32'd0);
        clear_tallies();
        step(10);
        check("t5_mask_p0", 32'(mask_p0), 32'h007F);
        check("t5_n_mnp0",  32'(n_mnp0),  32'd7);

        // Reset at CNT=5, then reload from the live inputs.
        set_ch(0, 2'b01, 16'd8);
        wait_pe("t6_wait_pe", 20);
        wait_cnt("t6_reach_cnt5", 5, 20);
        QRESET = 1'b1;
        step(1);
        check("t6_rst_cnt",  32'(CNT), 32'd0);
        check("t6_rst_mnp",  32'(MNP), 32'd0);
        QRESET = 1'b0;
        step(1);
        check("t6_reload_cnt", 32'(CNT), 32'd0);
        step(1);
        check("t6_restart_cnt",  32'(CNT),    32'd1);
        check("t6_restart_mnp0", 32'(MNP[0]), 32'd1);

        // P=1, prescale /2, negative duty with padding bits set.
        MCPER_I = 11'd1;
        MCPRE_I = 2'd1;
        set_ch(0, 2'b01, 16'hF801);
        wait_pe("t7_wait_pe", 20);
        clear_tallies();
        step(10);
        check("t7_n_pe",   32'(n_pe),   32'd5);
        check("t7_n_mnm0", 32'(n_mnm0), 32'd10);
        check("t7_n_mnp0", 32'(n_mnp0), 32'd0);

        // Padding bits between magnitude and sign are ignored.
        MCPER_I = 11'd10;
        MCPRE_I = 2'd0;
        set_ch(0, 2'b01, 16'h7803);
        wait_pe("t8_wait_pe", 10);
        clear_tallies();
        step(10);
        check("t8_mask_p0", 32'(mask_p0), 32'h0007);
        check("t8_n_mnm0",  32'(n_mnm0),  32'd0);

        // Writing period 0 disables at the next wrap.
        MCPER_I = 11'd0;
        wait_pe("t9_wait_pe", 20);
        clear_tallies();
        step(10);
        check("t9_n_pe",   32'(n_pe),   32'd0);
        check("t9_n_mnp0", 32'(n_mnp0), 32'd0);
        check("t9_cnt",    32'(CNT),    32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
